// File: rtl/binary_to_bcd_converter.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble, one bit per cycle).
// Inputs above 9999 saturate to 9999 and raise overflow; bcd_out changes only on completion.
module binary_to_bcd_converter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [13:0] MAX_VAL   = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] scratch_q, scratch_d;
  logic [15:0] adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic [15:0] bcd_q, bcd_d;

  always_comb begin
    adj = scratch_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_d     = (bin_in > MAX_VAL) ? MAX_VAL : bin_in;
          ovf_d     = (bin_in > MAX_VAL);
          cnt_d     = '0;
          scratch_d = '0;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        // Add-3 correction first, then shift the captured MSB into the BCD scratch.
        scratch_d = {adj[14:0], bin_q[13]};
        bin_d     = {bin_q[12:0], 1'b0};
        if (cnt_q == LAST_ITER) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bcd_d   = {adj[14:0], bin_q[13]};
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: doc/binary_to_bcd_converter.md
BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

Interface
REQ-001 Parameters: none; binary width 14, digit count 4, conversion length 14 cycles are fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request conversion of bin_in; sampled on rising clk.
REQ-005 bin_in  input  14  unsigned binary value to convert.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when bcd_out takes a new result.
REQ-008 bcd_out  output  16  four packed BCD digits {thousands, hundreds, tens, ones}, registered, feeds the 4-digit display driver bcd_in.
REQ-009 overflow  output  1  high when the last accepted bin_in exceeded 9999.

Function
REQ-010 The block SHALL be a state machine with states IDLE and SHIFT.
REQ-011 In IDLE, when start=1 at a rising edge: capture bin_in, enter SHIFT, clear the iteration counter, clear the 16-bit BCD scratch register, and set busy=1.
REQ-012 Capture saturation: if bin_in > 9999, the captured value SHALL be 9999 and overflow SHALL be set at the capture edge; otherwise overflow SHALL be cleared at the capture edge.
REQ-013 Each SHIFT cycle SHALL perform one shift-add-3 iteration:
- add 3 to every scratch nibble >= 5;
- then shift {scratch, captured value} left by one bit, MSB of the captured value entering scratch bit 0.
REQ-014 The iteration counter SHALL be 4 bits, counting 0..13; no other wrap-around is permitted.
REQ-015 On the edge completing iteration 13 (the 14th iteration):
- bcd_out SHALL load the final scratch value;
- done SHALL be 1 for exactly the following cycle;
- busy SHALL return to 0;
- state SHALL return to IDLE.
REQ-016 Latency: done SHALL be high exactly 14 clock cycles after the edge at which start was accepted.
REQ-017 start SHALL be ignored while busy=1; the captured value SHALL not change mid-conversion.
REQ-018 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back conversions with a 15-cycle period.
REQ-019 bcd_out SHALL hold its value between conversions and change only at a completion edge, so the display never shows partial results.
REQ-020 Every bcd_out nibble SHALL always be in the range 0..9.
REQ-021 overflow SHALL hold until the next accepted start.

Reset
REQ-022 While rst=1, regardless of clk:
- state=IDLE;
- busy=0, done=0, overflow=0;
- bcd_out=16'h0000;
- counter and scratch cleared.
REQ-023 Reset asserted mid-conversion SHALL abort the conversion with no done pulse and bcd_out=0.
REQ-024 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-025 Bench SHALL cover:
- reset, then start with bin_in=1234 -> busy for 14 cycles, then done pulse, bcd_out=16'h1234, overflow=0.
- bin_in=0 -> bcd_out=16'h0000; bin_in=9999 -> bcd_out=16'h9999, overflow=0.
- bin_in=12000 -> bcd_out=16'h9999, overflow=1; next conversion of 42 -> bcd_out=16'h0042, overflow=0.
- start with bin_in=5678, change bin_in to 1111 and pulse start at cycle 5 -> result 16'h5678, single done pulse.
- rst asserted at cycle 7 of a conversion -> busy=0, bcd_out=0, no done; next start with 305 -> bcd_out=16'h0305.
- start held high continuously with bin_in=10 -> done pulses every 15 cycles; bcd_out stays 16'h0010.
